fsrc_sysref_gen: RTL and testbench
==================================

FSRC_SYSREF_GEN -- requirements
Module: fsrc_sysref_gen

Interface
REQ-001 SHALL have parameter PERIOD_WIDTH, default 16, width of period and phase counter.
REQ-002 SHALL have parameter MATCH_WIDTH, default 4, width of alignment match counter.
REQ-003 SHALL have ports, in this order:
- clk  input  1  sole clock.
- reset  input  1  synchronous, active-high reset.
- cfg_enable  input  1  level; 1 = generator running.
- cfg_align_en  input  1  1 = align to sysref_ext; 0 = free-run.
- cfg_period  input  PERIOD_WIDTH  pulse period N in clk cycles.
- cfg_align_count  input  MATCH_WIDTH  consecutive aligned edges M required for lock.
- sysref_ext  input  1  external SYSREF, already synchronous to clk.
- align_err_clr  input  1  pulse; clears align_err.
- sysref_int  output  1  one-cycle internal SYSREF pulse, feeds tx_fsrc_ctrl.sysref_int.
- locked  output  1  phase locked to sysref_ext.
- align_err  output  1  sticky; misaligned edge seen while locked.
REQ-004 SHALL use only clk; the design has one clock, and reset is synchronous and active-high.

Function
REQ-005 SHALL register sysref_ext once (ext_d); edge = sysref_ext & ~ext_d.
REQ-006 SHALL implement states IDLE, WAIT_EDGE, CHECK, LOCKED, FREE.
REQ-007 SHALL latch cfg_period (Np) and cfg_align_count (Mp) on leaving IDLE; changes while running SHALL be ignored.
REQ-008 SHALL treat Np < 2 as 2.
REQ-009 IDLE: phase_cnt = 0, sysref_int = 0, locked = 0; on cfg_enable = 1, go to WAIT_EDGE if cfg_align_en = 1, else FREE.
REQ-010 Entering FREE from IDLE SHALL load phase_cnt = 0 and assert sysref_int in the first FREE cycle.
REQ-011 In all running states, phase_cnt SHALL advance 0..Np-1 and wrap to 0.
REQ-012 sysref_int SHALL be high exactly in cycles where phase_cnt = 0 in FREE, CHECK and LOCKED; pulse period SHALL be Np cycles.
REQ-013 WAIT_EDGE: phase_cnt frozen, no pulses.
REQ-014 WAIT_EDGE, on edge in cycle T: phase_cnt = 0 and sysref_int = 1 at T+1.
REQ-015 WAIT_EDGE, on edge: go to LOCKED if Mp = 0, else go to CHECK with match_cnt = 0.
REQ-016 Aligned edge: edge while phase_cnt = Np-1. Misaligned edge: edge at any other phase.
REQ-017 CHECK, aligned edge: match_cnt increments; when the increment reaches Mp, go to LOCKED with locked = 1 in the next cycle.
REQ-018 CHECK, misaligned edge: match_cnt = 0, phase_cnt reloaded to 0 (pulse next cycle), stay in CHECK; align_err unaffected.
REQ-019 LOCKED: locked = 1; aligned edges have no effect.
REQ-020 LOCKED, misaligned edge: behaviour per REQ-027/REQ-028.
REQ-021 cfg_enable = 0 in any state SHALL force IDLE next cycle; sysref_int, locked and phase_cnt SHALL be 0 from that cycle.
REQ-022 align_err SHALL be set on a misaligned edge in LOCKED and cleared by align_err_clr; simultaneous set and clear: set wins. It is retained across IDLE.
REQ-023 locked SHALL be 0 in IDLE, WAIT_EDGE, CHECK and FREE.

Reset
REQ-024 Reset SHALL force IDLE and phase_cnt = 0, match_cnt = 0, ext_d = 0.
REQ-025 Reset SHALL force sysref_int = 0, locked = 0 and align_err = 0; it overrides every other input, including mid-pulse.
REQ-026 The first cycle after reset release SHALL evaluate cfg_enable as from IDLE.

Configuration
REQ-027 With FSRC_SYSREF_RELOCK_EN defined, a misaligned edge in LOCKED SHALL set align_err, reload phase_cnt = 0 (pulse next cycle), clear locked, and go to CHECK with match_cnt = 0.
REQ-028 With FSRC_SYSREF_RELOCK_EN undefined, a misaligned edge in LOCKED SHALL set align_err only; phase_cnt continues and locked stays 1.

Verification
REQ-029 Free-run: align_en = 0, period = 10, enable at cycle 0 -> sysref_int at cycles 1, 11, 21...; locked stays 0.
REQ-030 Lock: align_en = 1, period = 8, align_count = 2, sysref_ext edges every 8 cycles from cycle 5 -> pulse at cycle 6, locked = 1 at cycle 22, pulses every 8 cycles.
REQ-031 Misalignment while locked, edge 3 cycles early:
- with FSRC_SYSREF_RELOCK_EN: align_err = 1, locked = 0, pulse one cycle after the early edge.
- without it: align_err = 1, locked stays 1, phase unchanged.
REQ-032 Boundary: period = 0 or 1 -> pulse every 2 cycles; align_count = 0 -> locked one cycle after the first edge.
REQ-033 Disable/reset mid-run: cfg_enable = 0 at phase 3 -> sysref_int = 0 and locked = 0 next cycle, align_err retained; reset -> all outputs 0; set and clr of align_err in the same cycle -> align_err = 1.

Source files
------------

// File: rtl/fsrc_sysref_gen.sv
// fsrc_sysref_gen
// ---------------------------------------------------------------------------
// Internal SYSREF generator for the FSRC transmit path. It produces a
// one-cycle sysref_int pulse every Np clk cycles. It can free-run, or it can
// phase-align to an external SYSREF (sysref_ext) that is already synchronous
// to clk. Lock is declared after Mp consecutive external edges land on the
// last phase of the internal period (phase Np-1).
//
// Optional feature (compile-time macro): FSRC_SYSREF_RELOCK_EN
//   defined   : a misaligned edge while locked re-phases the generator,
//               drops locked and restarts the alignment check.
//   undefined : a misaligned edge while locked only raises align_err.
//
// Ports
//   clk             sole clock
//   reset           synchronous, active-high reset
//   cfg_enable      level, 1 = generator running
//   cfg_align_en    1 = align to sysref_ext, 0 = free-run
//   cfg_period      pulse period N in clk cycles (values < 2 behave as 2)
//   cfg_align_count consecutive aligned edges M required for lock
//   sysref_ext      external SYSREF, synchronous to clk
//   align_err_clr   pulse, clears align_err
//   sysref_int      one-cycle internal SYSREF pulse (registered)
//   locked          phase locked to sysref_ext (registered)
//   align_err       sticky misalignment flag, survives disable
// ---------------------------------------------------------------------------
module fsrc_sysref_gen #(
   parameter int PERIOD_WIDTH = 16,
   parameter int MATCH_WIDTH  = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    cfg_enable,
   input  logic                    cfg_align_en,
   input  logic [PERIOD_WIDTH-1:0] cfg_period,
   input  logic [MATCH_WIDTH-1:0]  cfg_align_count,
   input  logic                    sysref_ext,
   input  logic                    align_err_clr,
   output logic                    sysref_int,
   output logic                    locked,
   output logic                    align_err
);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_EDGE,
      CHECK,
      LOCKED,
      FREE
   } state_t;

   localparam logic [PERIOD_WIDTH-1:0] P_ZERO = '0;
   localparam logic [PERIOD_WIDTH-1:0] P_ONE  = PERIOD_WIDTH'(1);
   localparam logic [PERIOD_WIDTH-1:0] P_TWO  = PERIOD_WIDTH'(2);
   localparam logic [MATCH_WIDTH-1:0]  M_ZERO = '0;
   localparam logic [MATCH_WIDTH-1:0]  M_ONE  = MATCH_WIDTH'(1);

   state_t                  state;
   logic                    ext_d;
   logic [PERIOD_WIDTH-1:0] np;          // period latched when leaving IDLE
   logic [MATCH_WIDTH-1:0]  mp;          // match target latched when leaving IDLE
   logic [PERIOD_WIDTH-1:0] phase_cnt;
   logic [MATCH_WIDTH-1:0]  match_cnt;

   logic                    ext_edge;
   logic                    phase_last;
   logic [PERIOD_WIDTH-1:0] phase_inc;
   logic [MATCH_WIDTH-1:0]  match_inc;
   logic [PERIOD_WIDTH-1:0] cfg_np;

   assign ext_edge   = sysref_ext & ~ext_d;
   // An edge is aligned when it arrives on the last phase, so the wrap to
   // phase 0 (and the internal pulse) follows in the very next cycle.
   assign phase_last = (phase_cnt == (np - P_ONE));
   assign phase_inc  = phase_last ? P_ZERO : (phase_cnt + P_ONE);
   assign match_inc  = match_cnt + M_ONE;
   // Periods of 0 or 1 cannot produce distinct pulses; clamp to 2.
   assign cfg_np     = (cfg_period < P_TWO) ? P_TWO : cfg_period;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         ext_d      <= 1'b0;
         np         <= P_TWO;
         mp         <= M_ZERO;
         phase_cnt  <= P_ZERO;
         match_cnt  <= M_ZERO;
         sysref_int <= 1'b0;
         locked     <= 1'b0;
         align_err  <= 1'b0;
      end else begin
         ext_d <= sysref_ext;

         // Sticky error: a set in the same cycle as a clear takes priority.
         if ((state == LOCKED) && ext_edge && !phase_last)
            align_err <= 1'b1;
         else if (align_err_clr)
            align_err <= 1'b0;

         if (!cfg_enable) begin
            state      <= IDLE;
            phase_cnt  <= P_ZERO;
            match_cnt  <= M_ZERO;
            sysref_int <= 1'b0;
            locked     <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  np        <= cfg_np;
                  mp        <= cfg_align_count;
                  phase_cnt <= P_ZERO;
                  match_cnt <= M_ZERO;
                  locked    <= 1'b0;
                  if (cfg_align_en) begin
                     state      <= WAIT_EDGE;
                     sysref_int <= 1'b0;
                  end else begin
                     // Free-run starts with a pulse in its first cycle.
                     state      <= FREE;
                     sysref_int <= 1'b1;
                  end
               end

               WAIT_EDGE: begin
                  // Phase stays frozen until the first external edge.
                  if (ext_edge) begin
                     phase_cnt  <= P_ZERO;
                     match_cnt  <= M_ZERO;
                     sysref_int <= 1'b1;
                     if (mp == M_ZERO) begin
                        state  <= LOCKED;
                        locked <= 1'b1;
                     end else begin
                        state  <= CHECK;
                     end
                  end else begin
                     sysref_int <= 1'b0;
                  end
               end

               CHECK: begin
                  if (ext_edge && phase_last) begin
                     phase_cnt  <= P_ZERO;
                     sysref_int <= 1'b1;
                     if (match_inc >= mp) begin
                        state     <= LOCKED;
                        locked    <= 1'b1;
                        match_cnt <= M_ZERO;
                     end else begin
                        match_cnt <= match_inc;
                     end
                  end else if (ext_edge) begin
                     // Misaligned: re-phase to this edge and restart counting.
                     phase_cnt  <= P_ZERO;
                     match_cnt  <= M_ZERO;
                     sysref_int <= 1'b1;
                  end else begin
                     phase_cnt  <= phase_inc;
                     sysref_int <= (phase_inc == P_ZERO);
                  end
               end

               LOCKED: begin
`ifdef FSRC_SYSREF_RELOCK_EN
                  if (ext_edge && !phase_last) begin
                     state      <= CHECK;
                     phase_cnt  <= P_ZERO;
                     match_cnt  <= M_ZERO;
                     sysref_int <= 1'b1;
                     locked     <= 1'b0;
                  end else begin
                     phase_cnt  <= phase_inc;
                     sysref_int <= (phase_inc == P_ZERO);
                  end
`else
                  // Misalignment is only flagged; the phase keeps running.
                  phase_cnt  <= phase_inc;
                  sysref_int <= (phase_inc == P_ZERO);
`endif
               end

               FREE: begin
                  phase_cnt  <= phase_inc;
                  sysref_int <= (phase_inc == P_ZERO);
               end

               default: begin
                  state      <= IDLE;
                  phase_cnt  <= P_ZERO;
                  match_cnt  <= M_ZERO;
                  sysref_int <= 1'b0;
                  locked     <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fsrc_sysref_gen.sv
// tb_fsrc_sysref_gen
// Directed bench for fsrc_sysref_gen. Cycle k is the interval after the k-th
// rising edge following the cycle in which cfg_enable is raised (cycle 0).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Expected values follow FSRC_SYSREF_RELOCK_EN the same way the design does.
module tb_fsrc_sysref_gen;

   logic        clk = 1'b0;
   logic        reset;
   logic        cfg_enable;
   logic        cfg_align_en;
   logic [15:0] cfg_period;
   logic [3:0]  cfg_align_count;
   logic        sysref_ext;
   logic        align_err_clr;
   logic        sysref_int;
   logic        locked;
   logic        align_err;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   fsrc_sysref_gen #(
      .PERIOD_WIDTH(16),
      .MATCH_WIDTH(4)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .cfg_enable     (cfg_enable),
      .cfg_align_en   (cfg_align_en),
      .cfg_period     (cfg_period),
      .cfg_align_count(cfg_align_count),
      .sysref_ext     (sysref_ext),
      .align_err_clr  (align_err_clr),
      .sysref_int     (sysref_int),
      .locked         (locked),
      .align_err      (align_err)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic obs, input logic exp);
      total++;
      $display("check %s observed=%b expected=%b", tag, obs, exp);
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   initial begin
      logic e_sys, e_lck, e_err;

      // ---- reset overrides an asserted enable ----
      reset = 1'b1; cfg_enable = 1'b1; cfg_align_en = 1'b0;
      cfg_period = 16'd10; cfg_align_count = 4'd0;
      sysref_ext = 1'b0; align_err_clr = 1'b0;
      step(); step(); step();
      chk("rst_sysref", sysref_int, 1'b0);
      chk("rst_locked", locked, 1'b0);
      chk("rst_err", align_err, 1'b0);

      // ---- free-run, period 10, enable already high at release ----
      reset = 1'b0;                     // cycle 0
      for (int c = 1; c <= 25; c++) begin
         step();
         if (c == 5) cfg_period = 16'd3;  // must be ignored while running
         chk($sformatf("free_sysref_c%0d", c), sysref_int, (c % 10) == 1);
         chk($sformatf("free_locked_c%0d", c), locked, 1'b0);
      end

      // ---- alignment, lock, early edge, disable at phase 3 ----
      reset = 1'b1; cfg_enable = 1'b0;
      step(); step();
      reset = 1'b0;
      step();
      cfg_enable = 1'b1; cfg_align_en = 1'b1;
      cfg_period = 16'd8; cfg_align_count = 4'd2;   // cycle 0
      for (int c = 1; c <= 35; c++) begin
         step();
         sysref_ext = (c == 5) || (c == 13) || (c == 21) || (c == 26);
         if (c == 33) cfg_enable = 1'b0;
`ifdef FSRC_SYSREF_RELOCK_EN
         e_sys = (c <= 33) && ((c == 6) || (c == 14) || (c == 22) ||
                               ((c >= 27) && (((c - 27) % 8) == 0)));
         e_lck = (c >= 22) && (c < 27);
`else
         e_sys = (c <= 33) && (c >= 6) && (((c - 6) % 8) == 0);
         e_lck = (c >= 22) && (c <= 33);
`endif
         e_err = (c >= 27);
         chk($sformatf("lock_sysref_c%0d", c), sysref_int, e_sys);
         chk($sformatf("lock_locked_c%0d", c), locked, e_lck);
         chk($sformatf("lock_err_c%0d", c), align_err, e_err);
      end
      sysref_ext = 1'b0;

      // ---- reset clears sticky error; period 0, align_count 0, set+clr ----
      reset = 1'b1;
      step(); step();
      chk("rst2_sysref", sysref_int, 1'b0);
      chk("rst2_locked", locked, 1'b0);
      chk("rst2_err", align_err, 1'b0);
      reset = 1'b0;
      cfg_enable = 1'b1; cfg_align_en = 1'b1;
      cfg_period = 16'd0; cfg_align_count = 4'd0;   // cycle 0
      for (int c = 1; c <= 11; c++) begin
         step();
         sysref_ext    = (c == 3) || (c == 8);
         align_err_clr = (c == 8) || (c == 10);
`ifdef FSRC_SYSREF_RELOCK_EN
         e_sys = (c == 4) || (c == 6) || (c == 8) || ((c >= 9) && (c % 2 == 1));
         e_lck = (c >= 4) && (c < 9);
`else
         e_sys = (c >= 4) && (c % 2 == 0);
         e_lck = (c >= 4);
`endif
         e_err = (c == 9) || (c == 10);
         chk($sformatf("m0_sysref_c%0d", c), sysref_int, e_sys);
         chk($sformatf("m0_locked_c%0d", c), locked, e_lck);
         chk($sformatf("m0_err_c%0d", c), align_err, e_err);
      end
      sysref_ext = 1'b0; align_err_clr = 1'b0;

      // ---- free-run period 1, reset asserted mid-run ----
      reset = 1'b1; cfg_enable = 1'b0;
      step(); step();
      reset = 1'b0;
      step();
      cfg_enable = 1'b1; cfg_align_en = 1'b0; cfg_period = 16'd1;  // cycle 0
      for (int c = 1; c <= 7; c++) begin
         step();
         if (c == 6) reset = 1'b1;
         chk($sformatf("p1_sysref_c%0d", c), sysref_int, (c <= 6) && (c % 2 == 1));
      end
      chk("p1_rst_locked", locked, 1'b0);
      chk("p1_rst_err", align_err, 1'b0);
      reset = 1'b0; cfg_enable = 1'b0;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
